// File: rtl/counter_ctrl.sv
// counter_ctrl: command sequencer for an external up/down counter.
// Decodes one-clock command pulses (clear > load > stop > start > dir) into
// an IDLE/RUN/PAUSE/LOAD/CLEAR/DONE state machine, and issues tick-qualified
// enable/load/clear strobes to the counter. Count is fed back for terminal
// detection (LIMIT when counting up, 0 when counting down).
// Optional feature macro: COUNTER_CTRL_AUTORELOAD_EN -- on terminal the
// controller reloads ctr_data and keeps running instead of stopping in DONE,
// counting reloads in reload_cnt (saturating at 255).
module counter_ctrl #(
   parameter int COUNT_SIZE   = 20,
   parameter int DATA_IN_SIZE = 6,
   parameter int LIMIT        = 999999
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_p,
   input  logic                    stop_p,
   input  logic                    clear_p,
   input  logic                    dir_p,
   input  logic                    load_p,
   input  logic                    tick,
   input  logic [DATA_IN_SIZE-1:0] data_in,
   input  logic [COUNT_SIZE-1:0]   count,
   output logic                    ctr_en,
   output logic                    ctr_load,
   output logic                    ctr_clear,
   output logic                    ctr_up_down,
   output logic [DATA_IN_SIZE-1:0] ctr_data,
   output logic [2:0]              state,
   output logic                    done,
   output logic [7:0]              reload_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      LOAD  = 3'd3,
      CLEAR = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [COUNT_SIZE-1:0] LIMIT_V = COUNT_SIZE'(LIMIT);

   state_t                  cur, nxt;
   logic                    dir_q, dir_d;
   logic [DATA_IN_SIZE-1:0] data_q;
   logic                    capture;
   logic                    terminal;
   logic                    cmd_ok;
   logic                    auto_q;
   logic                    auto_set;

   // Terminal depends on direction: top limit going up, zero going down.
   assign terminal = dir_q ? (count == LIMIT_V) : (count == '0);

   // clear/load are honoured in every legal state except CLEAR.
   assign cmd_ok = cur inside {IDLE, RUN, PAUSE, LOAD, DONE};

   // Next state, direction and capture; an accepted higher-priority command
   // masks every lower one and also wins over tick-driven transitions.
   always_comb begin
      nxt      = cur;
      dir_d    = dir_q;
      capture  = 1'b0;
      auto_set = 1'b0;
      if (cmd_ok && clear_p) begin
         nxt = CLEAR;
      end else if (cmd_ok && load_p) begin
         nxt     = LOAD;
         capture = 1'b1;
      end else begin
         case (cur)
            IDLE: begin
               if (start_p && !stop_p)
                  nxt = RUN;
               else if (dir_p && !start_p && !stop_p)
                  dir_d = ~dir_q;
            end
            RUN: begin
               if (stop_p)
                  nxt = PAUSE;
               else if (tick && terminal) begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                  nxt      = LOAD;
                  auto_set = 1'b1;
`else
                  nxt = DONE;
`endif
               end
            end
            PAUSE: begin
               if (stop_p)
                  nxt = IDLE;
               else if (start_p)
                  nxt = RUN;
               else if (dir_p)
                  dir_d = ~dir_q;
            end
            LOAD: begin
               // Auto-reload resumes counting; a user load parks in IDLE.
               if (tick)
                  nxt = auto_q ? RUN : IDLE;
            end
            CLEAR: begin
               if (tick)
                  nxt = IDLE;
            end
            DONE: begin
               if (dir_p && !start_p && !stop_p)
                  dir_d = ~dir_q;
            end
            default: nxt = IDLE;
         endcase
      end
   end

   // State, direction and load-value registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur    <= IDLE;
         dir_q  <= 1'b1;
         data_q <= '0;
      end else begin
         cur   <= nxt;
         dir_q <= dir_d;
         if (capture)
            data_q <= data_in;
      end
   end

`ifdef COUNTER_CTRL_AUTORELOAD_EN
   logic [7:0] rcnt_q;

   // Auto-reload flag lives only while in LOAD; reload counter saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         auto_q <= 1'b0;
         rcnt_q <= 8'd0;
      end else begin
         if (capture)
            auto_q <= 1'b0;
         else if (auto_set)
            auto_q <= 1'b1;
         else if (nxt != LOAD)
            auto_q <= 1'b0;
         if (cur == LOAD && tick && auto_q && !capture && !(clear_p && cmd_ok)
             && rcnt_q != 8'hFF)
            rcnt_q <= rcnt_q + 8'd1;
      end
   end

   assign reload_cnt = rcnt_q;
`else
   assign auto_q     = 1'b0;
   assign reload_cnt = 8'd0;
`endif

   assign state       = cur;
   assign done        = (cur == DONE);
   assign ctr_up_down = dir_q;
   assign ctr_data    = data_q;
   assign ctr_en      = (cur == RUN) & tick & ~terminal;
   assign ctr_load    = (cur == LOAD) & tick;
   assign ctr_clear   = (cur == CLEAR) & tick;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed + random bench for counter_ctrl. A behavioural
// counter in the bench follows the reference model's strobes and feeds count
// back to the DUT; every cycle all DUT outputs are compared to the model.
module tb_counter_ctrl;
   localparam int CS  = 8;
   localparam int DS  = 6;
   localparam int LIM = 9;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   // pulse vector bit order: {clear, load, stop, start, dir}
   localparam logic [4:0] P_CLR = 5'b10000, P_LD = 5'b01000, P_STOP = 5'b00100,
                          P_START = 5'b00010, P_DIR = 5'b00001, P_NONE = 5'b00000;

   logic clk = 1'b0;
   logic rst;
   logic start_p, stop_p, clear_p, dir_p, load_p, tick;
   logic [DS-1:0] data_in;
   logic [CS-1:0] plant;
   logic ctr_en, ctr_load, ctr_clear, ctr_up_down, done;
   logic [DS-1:0] ctr_data;
   logic [2:0] state;
   logic [7:0] reload_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // reference model
   int            m_st;
   logic          m_dir;
   logic [DS-1:0] m_data;
   logic          m_auto;
   int            m_rc;
   logic          s_en, s_ld, s_clr;

   // command effect per state (rows IDLE..DONE, cols clr,ld,stop,start,dir):
   // >=0 next state, -1 no effect, -2 toggle direction
   int tbl [0:5][0:4] = '{'{4, 3, -1,  1, -2},
                          '{4, 3,  2, -1, -1},
                          '{4, 3,  0,  1, -2},
                          '{4, 3, -1, -1, -1},
                          '{-1, -1, -1, -1, -1},
                          '{4, 3, -1, -1, -2}};

   always #5 clk = ~clk;

   counter_ctrl #(.COUNT_SIZE(CS), .DATA_IN_SIZE(DS), .LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .start_p(start_p), .stop_p(stop_p), .clear_p(clear_p),
      .dir_p(dir_p), .load_p(load_p), .tick(tick), .data_in(data_in), .count(plant),
      .ctr_en(ctr_en), .ctr_load(ctr_load), .ctr_clear(ctr_clear),
      .ctr_up_down(ctr_up_down), .ctr_data(ctr_data), .state(state), .done(done),
      .reload_cnt(reload_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_dir = 1'b1; m_data = '0; m_auto = 1'b0; m_rc = 0;
   endtask

   task automatic drive(input logic [4:0] p, input logic tk, input logic [DS-1:0] din);
      clear_p = p[4]; load_p = p[3]; stop_p = p[2]; start_p = p[1]; dir_p = p[0];
      tick = tk; data_in = din;
   endtask

   // One clock: drive, compare against model, advance model and counter.
   task automatic cyc(input logic [4:0] p, input logic tk, input logic [DS-1:0] din);
      logic term, e_en, e_ld, e_clr, n_dir, n_auto;
      logic [DS-1:0] n_data;
      logic [CS-1:0] n_plant;
      int win, act, n_st, n_rc;
      @(negedge clk);
      drive(p, tk, din);
      #1;
      term  = m_dir ? (plant == CS'(LIM)) : (plant == '0);
      e_en  = (m_st == 1) && tk && !term;
      e_ld  = (m_st == 3) && tk;
      e_clr = (m_st == 4) && tk;
      s_en = ctr_en; s_ld = ctr_load; s_clr = ctr_clear;
      chk("ctr_en", ctr_en, e_en);
      chk("ctr_load", ctr_load, e_ld);
      chk("ctr_clear", ctr_clear, e_clr);
      chk("state", state, m_st);
      chk("done", done, m_st == 5);
      chk("up_down", ctr_up_down, m_dir);
      chk("ctr_data", ctr_data, m_data);
      chk("reload_cnt", reload_cnt, m_rc);
      n_st = m_st; n_dir = m_dir; n_data = m_data; n_auto = m_auto; n_rc = m_rc;
      win = -1;
      for (int i = 4; i >= 0; i--)
         if (p[i] && win < 0) win = 4 - i;
      act = (win < 0) ? -1 : tbl[m_st][win];
      if (act == -2)
         n_dir = !m_dir;
      else if (act >= 0) begin
         n_st = act;
         if (win == 1) begin n_data = din; n_auto = 1'b0; end
      end else if (m_st == 1 && tk && term) begin
         if (AR) begin n_st = 3; n_auto = 1'b1; end
         else n_st = 5;
      end else if (m_st == 3 && tk) begin
         n_st = m_auto ? 1 : 0;
         if (m_auto && m_rc < 255) n_rc = m_rc + 1;
         n_auto = 1'b0;
      end else if (m_st == 4 && tk)
         n_st = 0;
      if (e_clr) n_plant = '0;
      else if (e_ld) n_plant = CS'(m_data);
      else if (e_en) n_plant = m_dir ? plant + 1'b1 : plant - 1'b1;
      else n_plant = plant;
      @(posedge clk);
      #1;
      m_st = n_st; m_dir = n_dir; m_data = n_data; m_auto = n_auto; m_rc = n_rc;
      plant = n_plant;
      drive(P_NONE, 1'b0, din);
   endtask

   // Asynchronous reset asserted away from any clock edge, tick held high.
   task automatic do_reset();
      @(negedge clk);
      #2;
      drive(P_NONE, 1'b1, '0);
      rst = 1'b0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_en", ctr_en, 0);
      chk("rst_load", ctr_load, 0);
      chk("rst_clear", ctr_clear, 0);
      chk("rst_done", done, 0);
      chk("rst_up_down", ctr_up_down, 1);
      chk("rst_data", ctr_data, 0);
      chk("rst_reload", reload_cnt, 0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_hold_state", state, 0);
      chk("rst_hold_load", ctr_load, 0);
      @(negedge clk);
      drive(P_NONE, 1'b0, '0);
      rst = 1'b1;
   endtask

   initial begin
      bit seen1;
      rst = 1'b0;
      plant = '0;
      drive(P_NONE, 1'b0, '0);
      model_reset();
      do_reset();
      for (int i = 0; i < 3; i++) cyc(P_NONE, i[0], '0);

      // run from zero, tick every 4 clocks, then pause
      cyc(P_START, 1'b0, '0);
      chk("run_state", state, 1);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 3; j++) cyc(P_NONE, 1'b0, '0);
         cyc(P_NONE, 1'b1, '0);
         chk("run_tick_en", s_en, 1);
      end
      cyc(P_STOP, 1'b0, '0);
      chk("pause_state", state, 2);
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) cyc(P_NONE, 1'b0, '0);
         cyc(P_NONE, 1'b1, '0);
         chk("pause_en", s_en, 0);
      end

      // user load of 37 from RUN, tick three clocks later
      cyc(P_START, 1'b0, '0);
      cyc(P_LD, 1'b0, 6'd37);
      chk("load_state", state, 3);
      cyc(P_NONE, 1'b0, '0);
      cyc(P_NONE, 1'b0, '0);
      cyc(P_NONE, 1'b1, '0);
      chk("load_strobe", s_ld, 1);
      chk("load_data", ctr_data, 37);
      chk("load_exit", state, 0);
      cyc(P_NONE, 1'b1, '0);
      chk("load_once", s_ld, 0);

      // count down from 1 to terminal
      cyc(P_DIR, 1'b0, '0);
      chk("dir_down", ctr_up_down, 0);
      cyc(P_LD, 1'b0, 6'd1);
      cyc(P_NONE, 1'b1, '0);
      cyc(P_START, 1'b0, '0);
      cyc(P_NONE, 1'b1, '0);
      chk("down_en", s_en, 1);
      cyc(P_NONE, 1'b1, '0);
      chk("term_no_en", s_en, 0);
`ifndef COUNTER_CTRL_AUTORELOAD_EN
      chk("done_state", state, 5);
      chk("done_flag", done, 1);
`endif
      cyc(P_DIR, 1'b0, '0);
`ifndef COUNTER_CTRL_AUTORELOAD_EN
      chk("done_dir_up", ctr_up_down, 1);
`endif

      // clear and load together in PAUSE: clear wins, data kept
      cyc(P_CLR, 1'b0, '0);
      cyc(P_NONE, 1'b1, '0);
      cyc(P_START, 1'b0, '0);
      cyc(P_STOP, 1'b0, '0);
      chk("pause2_state", state, 2);
      cyc(P_CLR | P_LD, 1'b0, 6'd55);
      chk("clr_state", state, 4);
      chk("clr_data_kept", ctr_data, 1);
      cyc(P_NONE, 1'b0, '0);
      chk("clr_wait", s_clr, 0);
      cyc(P_NONE, 1'b1, '0);
      chk("clr_strobe", s_clr, 1);
      chk("clr_exit", state, 0);

      // reset while LOAD is waiting for tick
      cyc(P_LD, 1'b0, 6'd20);
      cyc(P_NONE, 1'b0, '0);
      chk("pend_load", state, 3);
      do_reset();

      // random commands and ticks
      for (int n = 0; n < 800; n++) begin
         logic [4:0] p;
         for (int b = 0; b < 5; b++) p[b] = ($urandom % 14) == 0;
         cyc(p, ($urandom % 3) == 0, DS'($urandom));
      end

`ifdef COUNTER_CTRL_AUTORELOAD_EN
      // auto-reload from 3 to LIMIT, repeated until the counter saturates
      cyc(P_CLR, 1'b0, '0);
      cyc(P_NONE, 1'b1, '0);
      if (!m_dir) cyc(P_DIR, 1'b0, '0);
      cyc(P_LD, 1'b0, 6'd3);
      cyc(P_NONE, 1'b1, '0);
      cyc(P_START, 1'b0, '0);
      seen1 = 1'b0;
      for (int n = 0; n < 2200; n++) begin
         cyc(P_NONE, 1'b1, '0);
         if (!seen1 && m_rc == 1) begin
            seen1 = 1'b1;
            chk("ar_first_reload", reload_cnt, 1);
            chk("ar_back_to_run", state, 1);
         end
      end
      chk("ar_saturated", reload_cnt, 255);
`else
      seen1 = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
